decade_count_arbiter: RTL



---
 rtl/decade_count_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/decade_count_arbiter.sv
// decade_count_arbiter
//
// Round-robin owner of one external mod-10 up-counter shared by NREQ clients.
// A granted client gets the counter cleared, then enabled until it reaches the
// client's (clamped) target, after which a one-cycle done pulse is issued.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   i_req      per-client request level, held until done or dropped (abort)
//   i_tgt      packed targets, client i uses [CW*i +: CW]
//   i_cnt_val  current value of the external counter
//   o_cnt_en   counter enable (combinational on i_cnt_val while running)
//   o_cnt_clr  synchronous clear to the counter
//   o_gnt      one-hot grant
//   o_done     one-hot, one-cycle completion pulse
//   o_busy     high whenever the arbiter is not idle

module decade_count_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 4,
    parameter int unsigned MAXV = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [CW*NREQ-1:0]   i_tgt,
    input  logic [CW-1:0]        i_cnt_val,
    output logic                 o_cnt_en,
    output logic                 o_cnt_clr,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_done,
    output logic                 o_busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CW-1:0] MAXV_C = CW'(MAXV);

    logic [1:0]      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_tgt;

    logic [NREQ-1:0] w_rot;
    logic            w_found;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_sel;
    logic [CW-1:0]   w_tgt_raw;
    logic [CW-1:0]   w_tgt_clamp;
    logic            w_req_idx;
    logic [IW-1:0]   w_idx_inc;
    logic [NREQ-1:0] w_onehot;
    logic            w_hit;

    // Rotate requests so bit 0 is the pointer position; the first set bit of
    // the rotated vector is the winner, then map its offset back to an index.
    always_comb begin
        w_rot   = NREQ'({i_req, i_req} >> r_ptr);
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (IW+1)'(k);
            end
        end
        if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
        end
        w_sel = w_sum[IW-1:0];
    end

    // Target of the selected client, clamped to the largest legal value.
    always_comb begin
        w_tgt_raw = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_sel == IW'(i)) begin
                w_tgt_raw = i_tgt[i*CW +: CW];
            end
        end
        w_tgt_clamp = (w_tgt_raw > MAXV_C) ? MAXV_C : w_tgt_raw;
    end

    // Decode of the latched grant index.
    always_comb begin
        w_req_idx = 1'b0;
        w_onehot  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (r_idx == IW'(i)) begin
                w_req_idx   = i_req[i];
                w_onehot[i] = 1'b1;
            end
        end
        w_idx_inc = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
        w_hit     = (i_cnt_val == r_tgt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_tgt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_idx   <= w_sel;
                        r_tgt   <= w_tgt_clamp;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // A dropped request aborts without done but still advances
                    // the pointer so the aborting client goes to the back.
                    if (!w_req_idx) begin
                        r_ptr   <= w_idx_inc;
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= w_idx_inc;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Everything except the enable is a pure decode of state.
    always_comb begin
        o_busy    = (r_state != ST_IDLE);
        o_gnt     = o_busy ? w_onehot : '0;
        o_done    = (r_state == ST_DONE) ? w_onehot : '0;
        o_cnt_clr = (r_state == ST_CLEAR);
        o_cnt_en  = (r_state == ST_RUN) && !w_hit && w_req_idx;
    end

endmodule
